// File: rtl/tmds_decode.sv
// tmds_decode: TMDS receive channel decoder with token-based alignment and lock tracking.
// Optional feature macro: TMDS_DECODE_ERRCNT_EN (loss-of-lock event counter on err_count_out).
module tmds_decode #(
    parameter int LOCK_COUNT  = 8,
    parameter int SLIP_WINDOW = 64,
    parameter int LOSS_WINDOW = 2048
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [9:0] symbol_in,
    input  logic       symbol_valid_in,
    output logic [7:0] data_out,
    output logic [1:0] control_out,
    output logic       de_out,
    output logic       valid_out,
    output logic       locked_out,
    output logic       slip_out,
    output logic [15:0] err_count_out
);

    localparam int RW = $clog2(LOCK_COUNT) + 1;
    localparam int WW = $clog2(SLIP_WINDOW) + 1;
    localparam int LW = $clog2(LOSS_WINDOW) + 1;

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    state_t      r_state;
    logic [RW-1:0] r_run;
    logic [WW-1:0] r_window;
    logic [LW-1:0] r_loss;
    logic [7:0]  r_data;
    logic [1:0]  r_ctrl;
    logic        r_de;
    logic        r_valid;
    logic        r_locked;
    logic        r_slip;

    logic        w_is_tok;
    logic [1:0]  w_tok_val;
    logic [7:0]  w_b;
    logic [7:0]  w_d;
    logic [RW-1:0] w_run_inc;
    logic [WW-1:0] w_win_inc;
    logic [LW-1:0] w_loss_inc;

    // Classify the incoming symbol as one of the four control tokens.
    always_comb begin
        w_is_tok  = 1'b1;
        w_tok_val = 2'b00;
        case (symbol_in)
            10'b1101010100: w_tok_val = 2'b00;
            10'b0010101011: w_tok_val = 2'b01;
            10'b0101010100: w_tok_val = 2'b10;
            10'b1010101011: w_tok_val = 2'b11;
            default:        w_is_tok  = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    assign w_b = symbol_in[9] ? ~symbol_in[7:0] : symbol_in[7:0];
    assign w_d = {w_b[7:1] ^ w_b[6:0] ^ {7{~symbol_in[8]}}, w_b[0]};

    assign w_run_inc  = r_run + 1'b1;
    assign w_win_inc  = r_window + 1'b1;
    assign w_loss_inc = r_loss + 1'b1;

    // Output register stage plus the HUNT/LOCKED alignment FSM.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state  <= HUNT;
            r_run    <= '0;
            r_window <= '0;
            r_loss   <= '0;
            r_data   <= '0;
            r_ctrl   <= '0;
            r_de     <= 1'b0;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
            r_slip   <= 1'b0;
        end else begin
            r_slip  <= 1'b0;
            r_valid <= 1'b0;
            if (symbol_valid_in) begin
                if (w_is_tok) begin
                    r_ctrl <= w_tok_val;
                    r_de   <= 1'b0;
                end else begin
                    r_data <= w_d;
                    r_de   <= 1'b1;
                end
                r_valid <= (r_state == LOCKED);
                case (r_state)
                    HUNT: begin
                        if (w_is_tok) begin
                            r_window <= '0;
                            if (w_run_inc == RW'(LOCK_COUNT)) begin
                                r_state  <= LOCKED;
                                r_locked <= 1'b1;
                                r_valid  <= 1'b1;
                                r_run    <= '0;
                            end else begin
                                r_run <= w_run_inc;
                            end
                        end else begin
                            r_run <= '0;
                            if (w_win_inc == WW'(SLIP_WINDOW)) begin
                                r_slip   <= 1'b1;
                                r_window <= '0;
                            end else begin
                                r_window <= w_win_inc;
                            end
                        end
                    end
                    LOCKED: begin
                        if (w_is_tok) begin
                            r_loss <= '0;
                        end else if (w_loss_inc == LW'(LOSS_WINDOW)) begin
                            r_state  <= HUNT;
                            r_locked <= 1'b0;
                            r_valid  <= 1'b0;
                            r_loss   <= '0;
                            r_run    <= '0;
                            r_window <= '0;
                        end else begin
                            r_loss <= w_loss_inc;
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end
        end
    end

    assign data_out    = r_data;
    assign control_out = r_ctrl;
    assign de_out      = r_de;
    assign valid_out   = r_valid;
    assign locked_out  = r_locked;
    assign slip_out    = r_slip;

`ifdef TMDS_DECODE_ERRCNT_EN
    logic        w_loss_evt;
    logic [15:0] r_err;

    assign w_loss_evt = (r_state == LOCKED) && symbol_valid_in && !w_is_tok
                        && (w_loss_inc == LW'(LOSS_WINDOW));

    // Count LOCKED->HUNT transitions, saturating at all-ones.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_err <= '0;
        end else if (w_loss_evt && (r_err != 16'hFFFF)) begin
            r_err <= r_err + 16'd1;
        end
    end

    assign err_count_out = r_err;
`else
    assign err_count_out = 16'h0000;
`endif

endmodule

// File: doc/tmds_decode.md
# tmds_decode

Receive-side TMDS channel decoder for the HDMI/DVI input path. It takes one 10-bit symbol per cycle from the deserializer and produces a registered 8-bit pixel byte or a 2-bit control value. It recovers symbol alignment by hunting for control tokens and requesting deserializer bit-slips. It tracks lock so that downstream video logic only sees data from an aligned stream.

## Interface
Parameters:
- LOCK_COUNT, 8: consecutive control tokens required to declare lock.
- SLIP_WINDOW, 64: accepted symbols without a token while hunting before a bit-slip is requested.
- LOSS_WINDOW, 2048: accepted symbols without a token while locked before lock is dropped.

Ports (clock and reset first):
- clk_in  input  1  symbol clock.
- rst_in  input  1  reset, asynchronous, active-high.
- symbol_in  input  10  TMDS symbol, bit 0 first on the wire.
- symbol_valid_in  input  1  symbol_in is valid this cycle.
- data_out  output  8  decoded pixel byte.
- control_out  output  2  last decoded control value {C1,C0}.
- de_out  output  1  data_out holds a video data byte.
- valid_out  output  1  outputs updated from an accepted symbol while locked.
- locked_out  output  1  alignment lock.
- slip_out  output  1  one-cycle bit-slip request to the deserializer.
- err_count_out  output  16  loss-of-lock event count (see Configuration).

## Operation
- Decode of accepted symbol q:
  - If q[9]=1, invert q[7:0] first.
  - If q[8]=1 (XOR form): d[0]=q[0], d[i]=q[i]^q[i-1].
  - If q[8]=0 (XNOR form): d[0]=q[0], d[i]=~(q[i]^q[i-1]).
- Control tokens (exact 10-bit match): 1101010100→00, 0010101011→01, 0101010100→10, 1010101011→11. A token sets control_out and forces de_out=0. Any other symbol is data: de_out=1, data_out=d.
- FSM states HUNT and LOCKED. Reset enters HUNT.
- HUNT:
  - run counter increments on each accepted token and clears on each accepted non-token.
  - The accepted token that brings run to LOCK_COUNT moves the FSM to LOCKED.
  - window counter increments on each accepted non-token and clears on each token.
  - When window reaches SLIP_WINDOW: pulse slip_out for 1 cycle and clear window (and run).
- LOCKED:
  - loss counter clears on each accepted token and increments otherwise.
  - When loss reaches LOSS_WINDOW: return to HUNT, locked_out=0, clear all counters.
  - slip_out is never asserted while LOCKED.
- symbol_valid_in=0: no counter or state change. valid_out=0 next cycle. data_out, control_out and de_out hold.
- valid_out = accepted symbol AND locked. de_out and data_out still update during HUNT, but are qualified by valid_out.
- Counters are sized $clog2(param)+1 and never wrap.

## Timing
- One register stage: the symbol accepted at edge N appears on data_out/control_out/de_out/valid_out after edge N.
- locked_out updates on the same edge as the lock-completing token, so that token's own output has valid_out=1.
- slip_out is high for the cycle after the edge on which window reaches SLIP_WINDOW.
- Reset values (asynchronous, active-high; also applies mid-operation): data_out=0, control_out=0, de_out=0, valid_out=0, locked_out=0, slip_out=0, err_count_out=0, state HUNT, all counters 0.

## Configuration
- TMDS_DECODE_ERRCNT_EN defined: err_count_out increments by 1 on each LOCKED→HUNT transition and saturates at 16'hFFFF. Only rst_in clears it.
- Not defined: err_count_out is tied to 0 and no counter logic is built.

## Test plan
- Reset: assert rst_in mid-stream with locked_out=1 → all outputs 0 immediately, without waiting for a clock edge. Release, then 7 tokens → locked_out still 0.
- Lock: 8 consecutive 1101010100 → locked_out=1 after the 8th. That token gives valid_out=1, de_out=0, control_out=00.
- Data decode while locked: 0100000000 → data_out=0x00, de_out=1. 1111111111 → data_out=0x00. 0010101011 → control_out=01, de_out=0.
- Slip: in HUNT, 64 accepted non-token symbols → slip_out high exactly 1 cycle after the 64th and no other cycle. A further 64 produce a second pulse. Inserting symbol_valid_in=0 gaps does not advance the count.
- Loss: locked, 2047 data symbols then 1 token → stays locked. Then 2048 data symbols → locked_out=0. With the macro defined, err_count_out=1.
- Interrupted hunt: 5 tokens, 1 data symbol, 8 tokens → lock asserts on the 14th symbol, not earlier.
